psram_bus_bridge: RTL and testbench
===================================

// Module: psram_bus_bridge
// PURPOSE
//  CPU-bus responder that turns CPU6 byte reads/writes into PsramController word commands.
//  Sits between the CPU data bus (19-bit byte address, 8-bit data) and the PSRAM controller's
//  read/write/busy handshake. Runs entirely in the PSRAM clock domain (clk).
//  A one-word read buffer answers repeated reads of the same 16-bit word without a PSRAM access.
// PARAMETERS
//  BASE_ADDR  19'h00000  window base; the bridge responds only when (bus_addr & WIN_MASK) == BASE_ADDR
//  WIN_MASK   19'h70000  window decode mask
//  BUF_EN     1          1 = read buffer enabled, 0 = every read goes to PSRAM
// PORTS
//  clk             in   1   PSRAM-domain clock (81 MHz)
//  resetn          in   1   asynchronous, active-low reset
//  bus_req         in   1   level request; held until bus_ack
//  bus_we          in   1   1 = write, 0 = read; qualified by bus_req
//  bus_addr        in   19  byte address
//  bus_wdata       in   8   write byte
//  bus_ack         out  1   one-cycle completion pulse
//  bus_rdata       out  8   read byte; valid on the bus_ack cycle and held until the next ack
//  mem_read        out  1   one-cycle read command to PsramController
//  mem_write       out  1   one-cycle write command
//  mem_byte_write  out  1   asserted together with mem_write (always a byte write)
//  mem_addr        out  22  {3'b000, bus_addr} captured at accept
//  mem_din         out  16  {wdata, wdata}; the controller selects the lane by mem_addr[0]
//  mem_dout        in   16  read word; valid when mem_busy falls
//  mem_busy        in   1   controller busy (high during init and each access)
// BEHAVIOUR
//  - Reset values: all outputs 0, buffer valid = 0, state = INIT.
//  - INIT: wait for mem_busy=0 (PSRAM init), then go to IDLE. bus_req is ignored in INIT.
//  - IDLE: bus_req & in_window -> latch addr/we/wdata (accept).
//    - Read hit (BUF_EN & valid & tag==addr[18:1]) -> ACK.
//    - Otherwise -> ISSUE.
//    - Outside the window: no response, stay in IDLE.
//  - ISSUE: assert mem_read or mem_write (+mem_byte_write) for exactly one cycle -> WAIT_ACK.
//  - WAIT_ACK: wait for mem_busy=1 -> WAIT_DONE.
//  - WAIT_DONE: wait for mem_busy=0.
//    - On a read: capture mem_dout into the buffer, tag=addr[18:1], valid=1.
//    - Then -> ACK.
//  - ACK: bus_ack=1 for one cycle.
//    - bus_rdata = addr[0] ? word[15:8] : word[7:0], taken from the buffer or the fresh word.
//    - -> RELEASE.
//  - RELEASE: wait for bus_req=0 -> IDLE. A request is never accepted twice.
//  - Latency (cycles from req sampled to ack): buffer hit = 2; miss = 3 + controller busy time.
//  - Writes are write-through. If tag matches, the addressed byte lane in the buffer is updated
//    on accept. Otherwise the buffer is unchanged.
//  - bus_* inputs may change after accept; latched copies are used.
//  - resetn low mid-access: immediately back to INIT with all outputs 0 and the buffer invalid.
//    A half-issued PSRAM command is abandoned; the controller shares resetn.
//  - mem_read and mem_write are never high in the same cycle. No command is issued while mem_busy=1.
// STRUCTURE
//  - Shared package/include: state encodings (INIT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE, ACK,
//    RELEASE) and the 22-bit PSRAM address width constant.
//  - Single sub-module: psram_word_buffer.
//    - Holds 16-bit data, 18-bit tag and valid.
//    - Provides hit compare, byte-lane update and full-word fill.
//  - FSM and datapath stay in the top.
// TESTING
//  1. Reset release with mem_busy high for 100 cycles
//     -> no mem_read/mem_write; bus_req ignored until busy falls.
//  2. Read 0x00012; model returns 16'hBEEF
//     -> exactly one mem_read, mem_addr=22'h000012, ack with rdata=8'hEF.
//  3. Read 0x00013 immediately after test 2
//     -> no mem_read; ack 2 cycles after req; rdata=8'hBE.
//  4. Write 0x00013 = 8'h5A, then read 0x00013
//     -> mem_write and mem_byte_write pulse with mem_din=16'h5A5A; read hits and returns 8'h5A.
//  5. bus_req held high for 20 cycles after ack -> exactly one ack and one PSRAM command.
//  6. resetn low during WAIT_DONE, then a read of 0x00012
//     -> outputs 0 and state INIT; after init the read misses (buffer invalidated).

Source files
------------

// File: rtl/psram_bus_bridge_pkg.sv
// Shared definitions for the CPU-bus to PSRAM bridge: widths, FSM states and
// the byte-lane select helper.
package psram_bus_bridge_pkg;

    localparam int BUS_AW   = 19;
    localparam int PSRAM_AW = 22;
    localparam int TAG_W    = BUS_AW - 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        ACK,
        RELEASE
    } state_e;

    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/psram_word_buffer.sv
// One-word read buffer: tag compare is combinational, fill and byte-lane update
// take effect on the next clock; a lane update only lands when the tag matches.
module psram_word_buffer
    import psram_bus_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [15:0]      data_o,
    input  logic             lane_wr_i,
    input  logic             lane_hi_i,
    input  logic [7:0]       lane_dat_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic [15:0]      fill_dat_i
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [15:0]      data_q;

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_dat_i;
        end else if (lane_wr_i && hit_o) begin
            if (lane_hi_i) data_q[15:8] <= lane_dat_i;
            else           data_q[7:0]  <= lane_dat_i;
        end
    end

endmodule

// File: rtl/psram_bus_bridge.sv
// CPU byte bus to PSRAM word-command bridge with a one-word read buffer.
// Ack 2 cycles after accept on a buffer hit, 3 + controller busy time on a miss.
module psram_bus_bridge
    import psram_bus_bridge_pkg::*;
#(
    parameter logic [BUS_AW-1:0] BASE_ADDR = 19'h00000,
    parameter logic [BUS_AW-1:0] WIN_MASK  = 19'h70000,
    parameter bit                BUF_EN    = 1'b1
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic                bus_req,
    input  logic                bus_we,
    input  logic [BUS_AW-1:0]   bus_addr,
    input  logic [7:0]          bus_wdata,
    output logic                bus_ack,
    output logic [7:0]          bus_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_byte_write,
    output logic [PSRAM_AW-1:0] mem_addr,
    output logic [15:0]         mem_din,
    input  logic [15:0]         mem_dout,
    input  logic                mem_busy
);

    state_e            state_q, state_d;
    logic [BUS_AW-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [15:0]       din_q, din_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic              in_window;
    logic              buf_hit_raw;
    logic              buf_hit;
    logic [15:0]       buf_data;
    logic              buf_lane_wr;
    logic              buf_fill;

    assign in_window = (bus_addr & WIN_MASK) == BASE_ADDR;
    assign buf_hit   = BUF_EN && buf_hit_raw;

    psram_word_buffer u_buf (
        .clk          (clk),
        .resetn       (resetn),
        .lookup_tag_i (bus_addr[BUS_AW-1:1]),
        .hit_o        (buf_hit_raw),
        .data_o       (buf_data),
        .lane_wr_i    (buf_lane_wr),
        .lane_hi_i    (bus_addr[0]),
        .lane_dat_i   (bus_wdata),
        .fill_i       (buf_fill),
        .fill_tag_i   (addr_q[BUS_AW-1:1]),
        .fill_dat_i   (mem_dout)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        din_d       = din_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        buf_lane_wr = 1'b0;
        buf_fill    = 1'b0;
        unique case (state_q)
            INIT: begin
                if (!mem_busy) state_d = IDLE;
            end
            IDLE: begin
                if (bus_req && in_window) begin
                    addr_d = bus_addr;
                    we_d   = bus_we;
                    if (bus_we) begin
                        din_d       = {bus_wdata, bus_wdata};
                        buf_lane_wr = BUF_EN;
                        state_d     = ISSUE;
                    end else if (buf_hit) begin
                        word_d  = buf_data;
                        state_d = ACK;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Never launch a command on top of a controller that is still busy.
                if (!mem_busy) begin
                    rd_d    = !we_q;
                    wr_d    = we_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (mem_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!mem_busy) begin
                    if (!we_q) begin
                        word_d   = mem_dout;
                        buf_fill = BUF_EN;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!we_q) rdata_d = lane_sel(word_q, addr_q[0]);
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus_req) state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= INIT;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus_ack        = ack_q;
    assign bus_rdata      = rdata_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_byte_write = wr_q;
    assign mem_addr       = {{(PSRAM_AW-BUS_AW){1'b0}}, addr_q};
    assign mem_din        = din_q;

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Scoreboarded bench: a PSRAM controller model plus a reference of memory and
// buffer residency predicts commands and read data for directed and random traffic.
module tb_psram_bus_bridge;

    logic        clk;
    logic        resetn;
    logic        bus_req;
    logic        bus_we;
    logic [18:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte_write;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_busy;

    psram_bus_bridge dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_write (mem_byte_write),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_busy       (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [21:0] addr;
        logic [15:0] din;
    } cmd_t;

    typedef struct {
        bit          rd;
        logic [7:0]  rdata;
    } ack_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cmd_cnt = 0;
    int          ack_cnt = 0;
    logic [15:0] psram   [0:32767];
    logic [15:0] ref_mem [0:32767];
    bit          ref_valid;
    logic [17:0] ref_tag;
    cmd_t        exp_cmd_q[$];
    ack_t        exp_ack_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},  {28'b0, bus_ack, mem_read, mem_write, mem_byte_write}, 32'h0);
        check({tag, "_addr"},  {10'b0, mem_addr}, 32'h0);
        check({tag, "_din"},   {16'b0, mem_din}, 32'h0);
        check({tag, "_rdata"}, {24'b0, bus_rdata}, 32'h0);
    endtask

    // PSRAM controller model: busy during init and for a random time per command.
    initial begin : ctl_model
        int          ctl_cnt;
        bit          ctl_rd;
        logic [14:0] ctl_idx;
        cmd_t        e;
        mem_busy = 1'b1;
        mem_dout = '0;
        ctl_cnt  = 100;
        ctl_rd   = 1'b0;
        ctl_idx  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                mem_busy = 1'b1;
                ctl_cnt  = 100;
                ctl_rd   = 1'b0;
            end else if (mem_read || mem_write) begin
                cmd_cnt++;
                check("cmd_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
                check("cmd_while_busy", {31'b0, mem_busy}, 32'h0);
                check("byte_write_pair", {31'b0, mem_byte_write}, {31'b0, mem_write});
                if (exp_cmd_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_cmd: got wr=%0d addr=0x%0h, expected none", mem_write, mem_addr);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_type", {31'b0, mem_write}, {31'b0, e.wr});
                    check("cmd_addr", {10'b0, mem_addr}, {10'b0, e.addr});
                    if (e.wr) check("cmd_din", {16'b0, mem_din}, {16'b0, e.din});
                end
                ctl_idx = mem_addr[15:1];
                if (mem_write) begin
                    if (mem_addr[0]) psram[ctl_idx][15:8] = mem_din[15:8];
                    else             psram[ctl_idx][7:0]  = mem_din[7:0];
                end
                ctl_rd   = mem_read;
                mem_busy = 1'b1;
                mem_dout = 16'($urandom);
                ctl_cnt  = $urandom_range(3, 8);
            end else if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    mem_busy = 1'b0;
                    if (ctl_rd) mem_dout = psram[ctl_idx];
                end
            end
        end
    end

    initial begin : ack_monitor
        ack_t a;
        forever begin
            @(posedge clk);
            #1;
            if (bus_ack) begin
                ack_cnt++;
                if (exp_ack_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_ack: got ack rdata=0x%0h, expected no ack at %0t", bus_rdata, $time);
                end else begin
                    a = exp_ack_q.pop_front();
                    if (a.rd) check("rdata", {24'b0, bus_rdata}, {24'b0, a.rdata});
                end
            end
        end
    end

    // Reference: memory is the truth (write-through); the buffer holds the last word read.
    task automatic bus_access(input bit we, input logic [18:0] addr, input logic [7:0] wdata,
                              input int hold, output int lat);
        logic [14:0] idx;
        logic [15:0] w;
        bit          hit;
        cmd_t        c;
        ack_t        a;
        idx = addr[15:1];
        hit = !we && ref_valid && (ref_tag == addr[18:1]);
        w   = ref_mem[idx];
        if (we) begin
            if (addr[0]) w[15:8] = wdata;
            else         w[7:0]  = wdata;
            ref_mem[idx] = w;
            c.wr = 1'b1; c.addr = {3'b000, addr}; c.din = {wdata, wdata};
            exp_cmd_q.push_back(c);
            a.rd = 1'b0; a.rdata = 8'h00;
        end else begin
            if (!hit) begin
                c.wr = 1'b0; c.addr = {3'b000, addr}; c.din = 16'h0;
                exp_cmd_q.push_back(c);
            end
            a.rd = 1'b1; a.rdata = addr[0] ? w[15:8] : w[7:0];
            ref_valid = 1'b1;
            ref_tag   = addr[18:1];
        end
        exp_ack_q.push_back(a);
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        lat = 0;
        while (!bus_ack && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (!bus_ack) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack for addr 0x%0h", lat, addr);
        end
        bus_we = 1'($urandom); bus_addr = 19'($urandom); bus_wdata = 8'($urandom);
        repeat (hold) @(negedge clk);
        bus_req = 1'b0;
        if (hit) check("hit_latency", lat, 32'd2);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int c0;
        int a0;
        int wcnt;
        cmd_t c;
        resetn = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        ref_valid = 1'b0; ref_tag = '0;
        for (int i = 0; i < 32768; i++) begin
            psram[i]   = 16'(i * 40503 + 7);
            ref_mem[i] = psram[i];
        end
        psram[9]   = 16'hBEEF;
        ref_mem[9] = 16'hBEEF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Request raised during PSRAM init, then the first miss.
        bus_access(1'b0, 19'h00012, 8'h00, 0, lat);
        check("init_hold_off", {31'b0, lat >= 100}, 32'h1);
        check("first_read_cmds", cmd_cnt, 32'd1);

        c0 = cmd_cnt;
        bus_access(1'b0, 19'h00013, 8'h00, 0, lat);
        check("hit_no_cmd", cmd_cnt - c0, 32'd0);

        bus_access(1'b1, 19'h00013, 8'h5A, 0, lat);
        c0 = cmd_cnt;
        bus_access(1'b0, 19'h00013, 8'h00, 0, lat);
        check("write_update_hit", cmd_cnt - c0, 32'd0);

        c0 = cmd_cnt; a0 = ack_cnt;
        bus_access(1'b0, 19'h00100, 8'h00, 20, lat);
        check("hold_acks", ack_cnt - a0, 32'd1);
        check("hold_cmds", cmd_cnt - c0, 32'd1);

        for (int n = 0; n < 60; n++)
            bus_access($urandom_range(0, 9) < 3, 19'($urandom_range(0, 31)), 8'($urandom),
                       $urandom_range(0, 3), lat);

        c0 = cmd_cnt; a0 = ack_cnt;
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 19'h10012;
        repeat (10) @(negedge clk);
        bus_req = 1'b0;
        check("oow_acks", ack_cnt - a0, 32'd0);
        check("oow_cmds", cmd_cnt - c0, 32'd0);

        // Reset while the controller is busy with a read.
        c0 = cmd_cnt;
        c.wr = 1'b0; c.addr = 22'h000400; c.din = 16'h0;
        exp_cmd_q.push_back(c);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 19'h00400;
        wcnt = 0;
        while (cmd_cnt == c0 && wcnt < 200) begin
            @(negedge clk);
            wcnt++;
        end
        check("midreset_cmd_issued", cmd_cnt - c0, 32'd1);
        @(posedge clk);
        #2;
        resetn  = 1'b0;
        bus_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        ref_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        c0 = cmd_cnt;
        bus_access(1'b0, 19'h00012, 8'h00, 0, lat);
        check("post_reset_miss", cmd_cnt - c0, 32'd1);

        repeat (5) @(negedge clk);
        check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
        check("ack_queue_drained", exp_ack_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
